// File: rtl/cache_miss_ctrl.sv
// Miss sequencer for the 2-way data cache: dirty write-back, line refill, fill pulse, bus timeout.
// Optional CACHE_PERF_EN adds miss_count / wb_count performance counters.
module cache_miss_ctrl #(
    parameter int DATA_WIDTH        = 32,
    parameter int SET_ADDRESS_WIDTH = 2,
    parameter int TAG_WIDTH         = DATA_WIDTH - SET_ADDRESS_WIDTH - 2,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic                  hit,
    input  logic                  victim_dirty,
    input  logic [TAG_WIDTH-1:0]  victim_tag,
    input  logic [DATA_WIDTH-1:0] victim_data,
    output logic                  Stall,
    output logic                  MemReq,
    output logic                  MemWE,
    output logic [DATA_WIDTH-1:0] MemA,
    output logic [DATA_WIDTH-1:0] MemWD,
    input  logic                  MemAck,
    input  logic [DATA_WIDTH-1:0] MemRD,
    output logic                  FillEn,
    output logic [DATA_WIDTH-1:0] FillData,
    output logic                  BusErr
`ifdef CACHE_PERF_EN
    ,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WB, RF, FILL, ERR} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [DATA_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
    logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
    logic                  mem_we_q, mem_we_d;
    logic                  req;
    logic                  miss_start;
    logic                  unused_addr_bits;

    assign req              = MemRead | MemWrite;
    assign miss_start       = (state_q == IDLE) && req && !hit;
    assign unused_addr_bits = ^A[1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_addr_d = line_addr_q;
        mem_a_d     = mem_a_q;
        mem_wd_d    = mem_wd_q;
        mem_we_d    = mem_we_q;
        fill_data_d = fill_data_q;
        case (state_q)
            IDLE: begin
                if (miss_start) begin
                    line_addr_d = {A[DATA_WIDTH-1:2], 2'b00};
                    cnt_d       = '0;
                    if (victim_dirty) begin
                        state_d  = WB;
                        mem_a_d  = {victim_tag, A[SET_ADDRESS_WIDTH+1:2], 2'b00};
                        mem_wd_d = victim_data;
                        mem_we_d = 1'b1;
                    end else begin
                        state_d  = RF;
                        mem_a_d  = {A[DATA_WIDTH-1:2], 2'b00};
                        mem_we_d = 1'b0;
                    end
                end
            end
            WB: begin
                if (MemAck) begin
                    state_d  = RF;
                    mem_a_d  = line_addr_q;
                    mem_we_d = 1'b0;
                    cnt_d    = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RF: begin
                // An ack on the last allowed cycle still completes the refill.
                if (MemAck) begin
                    fill_data_d = MemRD;
                    state_d     = FILL;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FILL:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_addr_q <= '0;
            mem_a_q     <= '0;
            mem_wd_q    <= '0;
            mem_we_q    <= 1'b0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_addr_q <= line_addr_d;
            mem_a_q     <= mem_a_d;
            mem_wd_q    <= mem_wd_d;
            mem_we_q    <= mem_we_d;
            fill_data_q <= fill_data_d;
        end
    end

    // Bus strobes decode from state so reset drops them without waiting for a clock.
    assign Stall    = miss_start || (state_q != IDLE);
    assign MemReq   = (state_q == WB) || (state_q == RF);
    assign FillEn   = (state_q == FILL);
    assign BusErr   = (state_q == ERR);
    assign MemWE    = mem_we_q;
    assign MemA     = mem_a_q;
    assign MemWD    = mem_wd_q;
    assign FillData = fill_data_q;

`ifdef CACHE_PERF_EN
    logic [31:0] miss_q, miss_d;
    logic [31:0] wb_q, wb_d;

    always_comb begin
        miss_d = miss_q;
        wb_d   = wb_q;
        if (miss_start) begin
            miss_d = miss_q + 32'd1;
            if (victim_dirty) wb_d = wb_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            miss_q <= miss_d;
            wb_q   <= wb_d;
        end
    end

    assign miss_count = miss_q;
    assign wb_count   = wb_q;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed self-checking bench for cache_miss_ctrl: hit, clean/dirty misses, zero-delay ack,
// bus timeout, ack on the last allowed cycle, and asynchronous reset during write-back.
module tb_cache_miss_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MemRead, MemWrite, hit, victim_dirty, MemAck;
    logic [31:0] A, victim_data, MemRD;
    logic [27:0] victim_tag;
    logic        Stall, MemReq, MemWE, FillEn, BusErr;
    logic [31:0] MemA, MemWD, FillData;
`ifdef CACHE_PERF_EN
    logic [31:0] miss_count, wb_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int stall_cycles;
    logic fill_seen;

    cache_miss_ctrl dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .A            (A),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data),
        .Stall        (Stall),
        .MemReq       (MemReq),
        .MemWE        (MemWE),
        .MemA         (MemA),
        .MemWD        (MemWD),
        .MemAck       (MemAck),
        .MemRD        (MemRD),
        .FillEn       (FillEn),
        .FillData     (FillData),
        .BusErr       (BusErr)
`ifdef CACHE_PERF_EN
        ,
        .miss_count   (miss_count),
        .wb_count     (wb_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic h, input logic dirty);
        MemRead      = rd;
        MemWrite     = wr;
        A            = addr;
        hit          = h;
        victim_dirty = dirty;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST_N = 1'b0;
        MemRead = 0; MemWrite = 0; hit = 0; victim_dirty = 0; MemAck = 0;
        A = 0; victim_data = 0; MemRD = 0; victim_tag = 0;
        #13;
        check_output("reset_memreq", MemReq, 0);
        check_output("reset_stall", Stall, 0);
        check_output("reset_fillen", FillEn, 0);
        check_output("reset_buserr", BusErr, 0);
        check_output("reset_mema", MemA, 32'h0);
        tick();
        RST_N = 1'b1;

        // Read hit
        apply_stimulus(1, 0, 32'h40, 1, 0);
        check_output("hit_stall", Stall, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("hit_memreq", MemReq, 0);
        end

        // Clean read miss at 0x40, ack after three waiting cycles
        apply_stimulus(1, 0, 32'h40, 0, 0);
        check_output("clean_idle_stall", Stall, 1);
        check_output("clean_idle_memreq", MemReq, 0);
        tick();
        check_output("clean_rf_memreq", MemReq, 1);
        check_output("clean_rf_mema", MemA, 32'h40);
        check_output("clean_rf_memwe", MemWE, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_output("clean_rf_wait", {Stall, MemReq, FillEn}, 3'b110);
        end
        MemAck = 1; MemRD = 32'hDEADBEEF;
        tick();
        check_output("clean_fill_en", FillEn, 1);
        check_output("clean_fill_data", FillData, 32'hDEADBEEF);
        check_output("clean_fill_memreq", MemReq, 0);
        check_output("clean_fill_stall", Stall, 1);
        MemAck = 0; hit = 1;
        tick();
        check_output("clean_done", {Stall, MemReq, FillEn}, 3'b000);
        apply_stimulus(0, 0, 32'h0, 0, 0);

        // Dirty store miss at 0x104 with victim tag 0x2
        victim_tag = 28'h2; victim_data = 32'h55;
        apply_stimulus(0, 1, 32'h104, 0, 1);
        tick();
        A = 32'h999;
        check_output("dirty_wb_memreq", MemReq, 1);
        check_output("dirty_wb_memwe", MemWE, 1);
        check_output("dirty_wb_mema", MemA, 32'h24);
        check_output("dirty_wb_memwd", MemWD, 32'h55);
        MemAck = 1; MemRD = 32'h1234;
        tick();
        check_output("dirty_rf_memreq", MemReq, 1);
        check_output("dirty_rf_mema", MemA, 32'h104);
        check_output("dirty_rf_memwe", MemWE, 0);
        tick();
        check_output("dirty_fill", {FillEn, MemReq}, 2'b10);
        check_output("dirty_fill_data", FillData, 32'h1234);
        MemAck = 0; hit = 1;
        tick();
        check_output("dirty_done", Stall, 0);
`ifdef CACHE_PERF_EN
        check_output("perf_miss_count", miss_count, 32'd2);
        check_output("perf_wb_count", wb_count, 32'd1);
`endif
        apply_stimulus(0, 0, 32'h0, 0, 0);

        // Zero-delay ack: a clean miss stalls for exactly three cycles
        MemAck = 1; MemRD = 32'hA5A5A5A5;
        apply_stimulus(1, 0, 32'h80, 0, 0);
        stall_cycles = 0;
        fill_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (Stall) stall_cycles++;
            if (FillEn) begin
                fill_seen = 1;
                hit = 1;
            end
            tick();
        end
        check_output("zero_delay_stall_cycles", stall_cycles, 3);
        check_output("zero_delay_fill_seen", fill_seen, 1);
        MemAck = 0;
        apply_stimulus(0, 0, 32'h0, 0, 0);

        // Timeout: no ack for 64 cycles in RF
        apply_stimulus(1, 0, 32'hC0, 0, 0);
        tick();
        for (int i = 0; i < 63; i++) tick();
        check_output("timeout_last_wait", {MemReq, BusErr}, 2'b10);
        tick();
        check_output("timeout_buserr", BusErr, 1);
        check_output("timeout_memreq", MemReq, 0);
        check_output("timeout_stall", Stall, 1);
        apply_stimulus(0, 0, 32'h0, 1, 0);
        MemAck = 1;
        for (int i = 0; i < 3; i++) tick();
        check_output("err_sticky", {BusErr, Stall, MemReq, FillEn}, 4'b1100);
        MemAck = 0;
        RST_N = 0;
        #1;
        check_output("err_reset_buserr", BusErr, 0);
        tick();
        RST_N = 1;

        // Ack on the final allowed cycle still completes the refill
        apply_stimulus(1, 0, 32'h100, 0, 0);
        tick();
        for (int i = 0; i < 63; i++) tick();
        MemAck = 1; MemRD = 32'hCAFEF00D;
        tick();
        check_output("last_ack_fill", {FillEn, BusErr}, 2'b10);
        check_output("last_ack_data", FillData, 32'hCAFEF00D);
        MemAck = 0; hit = 1;
        tick();
        apply_stimulus(0, 0, 32'h0, 0, 0);

        // Asynchronous reset during write-back
        victim_tag = 28'h7; victim_data = 32'h77;
        apply_stimulus(1, 0, 32'h208, 0, 1);
        tick();
        check_output("rstwb_memreq_before", MemReq, 1);
        RST_N = 0;
        #1;
        check_output("rstwb_memreq_async", MemReq, 0);
        MemAck = 1;
        fill_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (FillEn) fill_seen = 1;
        end
        check_output("rstwb_no_fill", fill_seen, 0);
        MemAck = 0;
        apply_stimulus(0, 0, 32'h0, 0, 0);
        RST_N = 1;
        tick();
        check_output("rstwb_idle", {Stall, MemReq, FillEn, BusErr}, 4'b0000);
        check_output("rstwb_mema", MemA, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
